// File: rtl/local_input_unit_if.sv
// Local input port bundle between the PE injection link, the switch
// allocator and the local input unit. The unit uses the slave modport,
// and the PE/allocator side uses the master modport.
interface local_input_unit_if #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 20
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // PE -> unit
  logic [FLIT_W-1:0] in;
  logic              vi;
  // node identity (quasi-static)
  logic [1:0]        my_cluster;
  logic [1:0]        my_local;
  // allocator -> unit
  logic              grant;
  // unit -> allocator / PE
  logic [FLIT_W-1:0] head;
  logic              head_valid;
  logic              dst_here;
  logic              dst_cluster_eq;
  logic              co;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport slave (
    input  in, vi, my_cluster, my_local, grant,
    output head, head_valid, dst_here, dst_cluster_eq, co, count, overflow
  );

  modport master (
    output in, vi, my_cluster, my_local, grant,
    input  head, head_valid, dst_here, dst_cluster_eq, co, count, overflow
  );
endinterface

// File: rtl/local_input_unit.sv
// Credit-based receiving end of the PE injection link. Buffers incoming
// flits in a DEPTH-entry FIFO, presents the head flit with its destination
// classification to the switch allocator, and returns one credit pulse per
// flit drained.
module local_input_unit #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 20
) (
  input logic              clk,
  input logic              rst,
  local_input_unit_if.slave lbus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Flit field positions: {dst_cluster, dst_local, payload}
  localparam int CL_HI = FLIT_W - 1;
  localparam int CL_LO = FLIT_W - 2;
  localparam int LC_HI = FLIT_W - 3;
  localparam int LC_LO = FLIT_W - 4;

  // FIFO storage; contents need no reset since head is gated by occupancy.
  logic [FLIT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             co_q,     co_d;
  logic             overflow_q, overflow_d;

  logic empty;
  logic full;
  logic deq;
  logic enq;
  logic drop;
  logic [FLIT_W-1:0] head_raw;
  logic [FLIT_W-1:0] head_flit;
  logic              cluster_match;
  logic              local_match;

  // Occupancy flags and handshake decode. Full is judged after a same-cycle
  // dequeue, so a grant on a full FIFO makes room for the arriving flit.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_COUNT);
    deq   = lbus.grant & ~empty;
    enq   = lbus.vi & (~full | deq);
    drop  = lbus.vi & full & ~deq;
  end

  // Next-state for pointers, occupancy, credit pulse and sticky overflow.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    co_d       = deq;
    overflow_d = overflow_q | drop;
    if (deq) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (enq) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: asynchronous clear so a reset discards buffered flits
  // and cancels any pending credit immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      co_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      co_q       <= co_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write: one entry per slot, written when the write pointer selects it.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (enq && (wr_ptr_q == PTR_W'(gi))) begin
          mem_q[gi] <= lbus.in;
        end
      end
    end
  endgenerate

  // Head read is combinational from registered storage so a flit written on
  // one edge is grantable in the very next cycle.
  always_comb begin
    head_raw      = mem_q[rd_ptr_q];
    head_flit     = empty ? '0 : head_raw;
    cluster_match = (head_flit[CL_HI:CL_LO] == lbus.my_cluster);
    local_match   = (head_flit[LC_HI:LC_LO] == lbus.my_local);
  end

  assign lbus.head           = head_flit;
  assign lbus.head_valid     = ~empty;
  assign lbus.dst_cluster_eq = ~empty & cluster_match;
  assign lbus.dst_here       = ~empty & cluster_match & local_match;
  assign lbus.co             = co_q;
  assign lbus.count          = count_q;
  assign lbus.overflow       = overflow_q;
endmodule

// File: tb/tb_local_input_unit.sv
// Directed bench for local_input_unit (DEPTH=4): reset, classification,
// fill/overflow/drain, full bypass, continuous stream and grant-while-empty.
module tb_local_input_unit;
  localparam int DEPTH  = 4;
  localparam int FLIT_W = 20;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   co_seen;

  local_input_unit_if #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) lbus ();

  local_input_unit #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .lbus (lbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    co_seen     = 0;
    rst = 1'b1;
    lbus.in = '0;
    lbus.vi = 1'b0;
    lbus.grant = 1'b0;
    lbus.my_cluster = 2'd2;
    lbus.my_local = 2'd1;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset / idle
    chk("rst_head_valid", 32'(lbus.head_valid), 32'd0);
    chk("rst_head", 32'(lbus.head), 32'd0);
    chk("rst_co", 32'(lbus.co), 32'd0);
    chk("rst_count", 32'(lbus.count), 32'd0);
    chk("rst_overflow", 32'(lbus.overflow), 32'd0);
    chk("rst_dst_here", 32'(lbus.dst_here), 32'd0);

    // Classification
    lbus.in = 20'h9ABCD; lbus.vi = 1'b1; step(); lbus.vi = 1'b0;
    chk("cls1_head", 32'(lbus.head), 32'h9ABCD);
    chk("cls1_dst_here", 32'(lbus.dst_here), 32'd1);
    chk("cls1_cl_eq", 32'(lbus.dst_cluster_eq), 32'd1);
    chk("cls1_count", 32'(lbus.count), 32'd1);
    lbus.in = 20'hA0001; lbus.vi = 1'b1; step(); lbus.vi = 1'b0;
    chk("cls2_count", 32'(lbus.count), 32'd2);
    lbus.grant = 1'b1; step(); lbus.grant = 1'b0;
    chk("cls2_head", 32'(lbus.head), 32'hA0001);
    chk("cls2_dst_here", 32'(lbus.dst_here), 32'd0);
    chk("cls2_cl_eq", 32'(lbus.dst_cluster_eq), 32'd1);
    chk("cls2_co", 32'(lbus.co), 32'd1);
    lbus.my_local = 2'd2; #1;
    chk("id_change_dst_here", 32'(lbus.dst_here), 32'd1);
    lbus.my_local = 2'd1; #1;
    step();
    chk("cls2_co_off", 32'(lbus.co), 32'd0);
    lbus.grant = 1'b1; step(); lbus.grant = 1'b0;
    chk("cls_empty_count", 32'(lbus.count), 32'd0);
    chk("cls_empty_hv", 32'(lbus.head_valid), 32'd0);
    chk("cls_empty_head", 32'(lbus.head), 32'd0);
    chk("cls_empty_dst", 32'(lbus.dst_cluster_eq), 32'd0);
    chk("cls_last_co", 32'(lbus.co), 32'd1);
    step();
    chk("cls_last_co_off", 32'(lbus.co), 32'd0);

    // Fill to full, then overflow
    for (int i = 1; i <= 4; i++) begin
      lbus.in = 20'(32'h11111 * i); lbus.vi = 1'b1; step();
    end
    lbus.vi = 1'b0;
    chk("fill_count", 32'(lbus.count), 32'd4);
    chk("fill_overflow", 32'(lbus.overflow), 32'd0);
    lbus.in = 20'h55555; lbus.vi = 1'b1; step(); lbus.vi = 1'b0;
    chk("ovf_flag", 32'(lbus.overflow), 32'd1);
    chk("ovf_count", 32'(lbus.count), 32'd4);
    chk("ovf_head", 32'(lbus.head), 32'h11111);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d_head", i), 32'(lbus.head), 32'h11111 * i);
      lbus.grant = 1'b1; step(); lbus.grant = 1'b0;
      chk($sformatf("drain%0d_co", i), 32'(lbus.co), 32'd1);
      step();
      chk($sformatf("drain%0d_co_off", i), 32'(lbus.co), 32'd0);
    end
    chk("drain_count", 32'(lbus.count), 32'd0);
    chk("drain_ovf_sticky", 32'(lbus.overflow), 32'd1);

    // Reset mid-stream with 3 flits buffered and a credit pending
    for (int i = 0; i < 3; i++) begin
      lbus.in = 20'h70000 + 20'(i); lbus.vi = 1'b1; step();
    end
    lbus.vi = 1'b0;
    chk("mid_count3", 32'(lbus.count), 32'd3);
    lbus.grant = 1'b1; step(); lbus.grant = 1'b0;
    chk("mid_co_pending", 32'(lbus.co), 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_count", 32'(lbus.count), 32'd0);
    chk("mid_rst_co", 32'(lbus.co), 32'd0);
    chk("mid_rst_hv", 32'(lbus.head_valid), 32'd0);
    chk("mid_rst_ovf", 32'(lbus.overflow), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_co", 32'(lbus.co), 32'd0);
    chk("post_rst_count", 32'(lbus.count), 32'd0);

    // Full with simultaneous enqueue and dequeue
    for (int i = 1; i <= 4; i++) begin
      lbus.in = 20'h0A000 + 20'(i); lbus.vi = 1'b1; step();
    end
    lbus.in = 20'h0A005; lbus.vi = 1'b1; lbus.grant = 1'b1; step();
    lbus.vi = 1'b0; lbus.grant = 1'b0;
    chk("byp_count", 32'(lbus.count), 32'd4);
    chk("byp_overflow", 32'(lbus.overflow), 32'd0);
    chk("byp_co", 32'(lbus.co), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("byp_order%0d", i), 32'(lbus.head), 32'h0A000 + i);
      lbus.grant = 1'b1; step(); lbus.grant = 1'b0;
    end
    chk("byp_drain_count", 32'(lbus.count), 32'd0);

    // Continuous stream of 20 flits with grant every cycle
    step();
    co_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) chk($sformatf("strm%0d_head", i), 32'(lbus.head), 32'hC0000 + i - 1);
      lbus.in = 20'hC0000 + 20'(i); lbus.vi = 1'b1; lbus.grant = 1'b1;
      step();
      if (lbus.co) co_seen++;
      chk($sformatf("strm%0d_count", i), 32'(lbus.count), 32'd1);
    end
    lbus.vi = 1'b0;
    chk("strm_last_head", 32'(lbus.head), 32'hC0013);
    step();
    lbus.grant = 1'b0;
    if (lbus.co) co_seen++;
    chk("strm_end_count", 32'(lbus.count), 32'd0);
    chk("strm_co_total", 32'(co_seen), 32'd20);
    step();
    chk("strm_co_off", 32'(lbus.co), 32'd0);

    // Grant while empty, then one flit and one grant
    lbus.grant = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("empty_grant%0d_co", i), 32'(lbus.co), 32'd0);
    end
    chk("empty_grant_count", 32'(lbus.count), 32'd0);
    lbus.in = 20'h12345; lbus.vi = 1'b1; step(); lbus.vi = 1'b0;
    chk("eg_write_count", 32'(lbus.count), 32'd1);
    chk("eg_write_co", 32'(lbus.co), 32'd0);
    chk("eg_write_head", 32'(lbus.head), 32'h12345);
    step();
    lbus.grant = 1'b0;
    chk("eg_deq_co", 32'(lbus.co), 32'd1);
    chk("eg_deq_count", 32'(lbus.count), 32'd0);
    step();
    chk("eg_co_off", 32'(lbus.co), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
